// File: rtl/regs_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//
// Contents:
//   arb_state_t : S_INIT (clear sequence running) / S_RUN (normal sharing)
//   req_id_t    : which requester owns the write port in a given cycle
//   REG_FIRST / REG_LAST / REG_ZERO : register-number landmarks
package regs_arb_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_WB   = 2'd0,
        REQ_INT  = 2'd1,
        REQ_DBG  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_t;

    localparam logic [4:0] REG_FIRST = 5'd1;
    localparam logic [4:0] REG_LAST  = 5'd31;
    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/regs_wt_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the interrupt unit and the debug port.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset; pointer returns to favouring INT
//   req  : req[0] = INT request, req[1] = DBG request
//   adv  : the grant is actually taken this cycle, so the pointer may move
//   gnt  : one-hot grant, same bit order as req
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic favour_int;

    // Only a real conflict consults the pointer; a lone request is
    // granted directly.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = favour_int ? 2'b01 : 2'b10;
        end
    end

    // The pointer flips towards whoever was not just served, and only on
    // cycles where the grant is actually consumed by the top level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            favour_int <= 1'b1;
        end else if (adv && gnt[0]) begin
            favour_int <= 1'b0;
        end else if (adv && gnt[1]) begin
            favour_int <= 1'b1;
        end
    end

endmodule

// File: rtl/regs_wt_arbiter.sv
// Owner of the single write port of the 32x32 register file.
//
// After reset an optional clear sequence writes INIT_VAL to $1..$31, then
// the port is shared between the WB stage (fixed top priority, no
// handshake), the interrupt unit and the debug/loader port (both
// valid/ready, round-robin between them).
//
// Ports:
//   clk, rst                      : clock / synchronous active-low reset
//   wb_we, wb_addr, wb_data       : WB stage write request
//   int_valid/addr/data, int_ready: interrupt unit request + accept
//   dbg_valid/addr/data, dbg_ready: debug port request + accept
//   wt, reg_wt_addr, Data_in      : registered write port to regs
//   init_busy                     : clear sequence still running
//   stall_cnt                     : saturating count of blocked requester-cycles
module regs_wt_arbiter
    import regs_arb_pkg::*;
#(
    parameter bit          INIT_CLEAR = 1'b1,
    parameter logic [31:0] INIT_VAL   = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             int_valid,
    input  logic [4:0]       int_addr,
    input  logic [31:0]      int_data,
    output logic             int_ready,
    input  logic             dbg_valid,
    input  logic [4:0]       dbg_addr,
    input  logic [31:0]      dbg_data,
    output logic             dbg_ready,
    output logic             wt,
    output logic [4:0]       reg_wt_addr,
    output logic [31:0]      Data_in,
    output logic             init_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    arb_state_t       state_q, state_d;
    logic [4:0]       cp_q, cp_d;
    logic             wt_d;
    logic [4:0]       addr_d;
    logic [31:0]      data_d;
    logic [1:0]       rr_gnt;
    logic             run_open;
    req_id_t          src;
    logic [1:0]       blocked_n;
    logic [CNT_W:0]   stall_sum;
    logic [CNT_W-1:0] stall_d;

    assign init_busy = (state_q == S_INIT);

    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .req ({dbg_valid, int_valid}),
        .adv (run_open),
        .gnt (rr_gnt)
    );

    // Handshake side: INT/DBG can only be accepted in RUN, when WB is idle
    // and reset is released, so nothing is acked in a cycle that reset
    // is about to throw away.
    always_comb begin
        run_open  = rst && (state_q == S_RUN) && !wb_we;
        int_ready = run_open && rr_gnt[0];
        dbg_ready = run_open && rr_gnt[1];
    end

    // Pick the owner of the port for this cycle and build the next output
    // word. With no owner, a pending clear step uses the port; otherwise
    // the port idles and keeps the last address/data. Writes to $0 are
    // accepted but never reach the register file.
    always_comb begin
        state_d = state_q;
        cp_d    = cp_q;
        wt_d    = 1'b0;
        addr_d  = reg_wt_addr;
        data_d  = Data_in;
        src     = REQ_NONE;

        if (wb_we) begin
            src = REQ_WB;
        end else if (int_ready) begin
            src = REQ_INT;
        end else if (dbg_ready) begin
            src = REQ_DBG;
        end

        case (src)
            REQ_WB: begin
                wt_d   = (wb_addr != REG_ZERO);
                addr_d = wb_addr;
                data_d = wb_data;
            end
            REQ_INT: begin
                wt_d   = (int_addr != REG_ZERO);
                addr_d = int_addr;
                data_d = int_data;
            end
            REQ_DBG: begin
                wt_d   = (dbg_addr != REG_ZERO);
                addr_d = dbg_addr;
                data_d = dbg_data;
            end
            default: begin
                if (state_q == S_INIT) begin
                    wt_d   = 1'b1;
                    addr_d = cp_q;
                    data_d = INIT_VAL;
                    cp_d   = cp_q + 5'd1;
                    if (cp_q == REG_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    // Each handshake requester that is asserting valid without getting
    // ready adds one; the sum is clamped at all-ones.
    always_comb begin
        blocked_n = {1'b0, int_valid && !int_ready} + {1'b0, dbg_valid && !dbg_ready};
        stall_sum = {1'b0, stall_cnt} + {{(CNT_W-1){1'b0}}, blocked_n};
        stall_d   = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
    end

    // Registered write port and bookkeeping. Reset drops any in-flight
    // write and restarts the clear sequence from $1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= INIT_CLEAR ? S_INIT : S_RUN;
            cp_q        <= REG_FIRST;
            wt          <= 1'b0;
            reg_wt_addr <= REG_ZERO;
            Data_in     <= 32'h0;
            stall_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            cp_q        <= cp_d;
            wt          <= wt_d;
            reg_wt_addr <= addr_d;
            Data_in     <= data_d;
            stall_cnt   <= stall_d;
        end
    end

endmodule

// File: tb/tb_regs_wt_arbiter.sv
// Self-checking bench for regs_wt_arbiter.
//
// A reference model tracks the remaining clear work as a queue of register
// numbers and the round-robin preference as a single flag; a compare
// process checks every DUT output against it on each falling edge. The
// directed sequences additionally pin hand-computed literal values.
module tb_regs_wt_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        int_valid = 1'b0;
    logic [4:0]  int_addr = '0;
    logic [31:0] int_data = '0;
    logic        int_ready;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_ready;
    logic        wt;
    logic [4:0]  reg_wt_addr;
    logic [31:0] Data_in;
    logic        init_busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    regs_wt_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .int_valid   (int_valid),
        .int_addr    (int_addr),
        .int_data    (int_data),
        .int_ready   (int_ready),
        .dbg_valid   (dbg_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_ready   (dbg_ready),
        .wt          (wt),
        .reg_wt_addr (reg_wt_addr),
        .Data_in     (Data_in),
        .init_busy   (init_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int unsigned clear_q[$];
    bit          favour_int = 1'b1;
    bit          model_live = 1'b0;
    logic        m_wt = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;

    function automatic bit m_int_ready();
        return rst && clear_q.size() == 0 && !wb_we && int_valid && (!dbg_valid || favour_int);
    endfunction

    function automatic bit m_dbg_ready();
        return rst && clear_q.size() == 0 && !wb_we && dbg_valid && (!int_valid || !favour_int);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [4:0] ia, input logic [31:0] id,
                                 input logic dv, input logic [4:0] da, input logic [31:0] dd);
        rst = r;
        wb_we = we;   wb_addr = wa;  wb_data = wd;
        int_valid = iv; int_addr = ia; int_data = id;
        dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Model step: what the port must carry after this edge.
    always @(posedge clk) begin
        bit ir, dr;
        int blocked;
        ir = m_int_ready();
        dr = m_dbg_ready();
        if (!rst) begin
            clear_q.delete();
            for (int r = 1; r <= 31; r++) clear_q.push_back(r);
            favour_int = 1'b1;
            m_wt = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_cnt = 0;
            model_live = 1'b1;
        end else begin
            blocked = int'(int_valid && !ir) + int'(dbg_valid && !dr);
            m_cnt = (m_cnt + blocked > 65535) ? 65535 : m_cnt + blocked;
            if (wb_we) begin
                m_wt = (wb_addr != 0); m_addr = wb_addr; m_data = wb_data;
            end else if (clear_q.size() > 0) begin
                m_wt = 1'b1; m_addr = 5'(clear_q.pop_front()); m_data = 32'h0;
            end else if (ir) begin
                m_wt = (int_addr != 0); m_addr = int_addr; m_data = int_data;
                favour_int = 1'b0;
            end else if (dr) begin
                m_wt = (dbg_addr != 0); m_addr = dbg_addr; m_data = dbg_data;
                favour_int = 1'b1;
            end else begin
                m_wt = 1'b0;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("m_wt",        32'(wt),          32'(m_wt));
            checkOutput("m_addr",      32'(reg_wt_addr), 32'(m_addr));
            checkOutput("m_data",      Data_in,          m_data);
            checkOutput("m_init_busy", 32'(init_busy),   32'(clear_q.size() > 0));
            checkOutput("m_stall_cnt", 32'(stall_cnt),   m_cnt);
            checkOutput("m_int_ready", 32'(int_ready),   32'(m_int_ready()));
            checkOutput("m_dbg_ready", 32'(dbg_ready),   32'(m_dbg_ready()));
        end
    end

    initial begin
        // Reset and full clear sequence, interrupt waiting throughout.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        applyStimulus(1, 0, 0, 0, 1, 5'd7, 32'h7777_0000, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_wt",    32'(wt), 0);
        checkOutput("rst_addr",  32'(reg_wt_addr), 0);
        checkOutput("rst_data",  Data_in, 0);
        checkOutput("rst_busy",  32'(init_busy), 1);
        checkOutput("rst_stall", 32'(stall_cnt), 0);
        for (int i = 1; i <= 31; i++) begin
            nextCycle();
            if (i == 30) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("clr_wt",        32'(wt), 1);
            checkOutput("clr_addr",      32'(reg_wt_addr), i);
            checkOutput("clr_data",      Data_in, 0);
            checkOutput("clr_busy",      32'(init_busy), 32'(i < 31));
            checkOutput("clr_int_ready", 32'(int_ready), 0);
        end
        checkOutput("clr_stall", 32'(stall_cnt), 30);

        // WB write injected in the third clear cycle.
        doReset();
        @(negedge clk);
        checkOutput("rst2_stall", 32'(stall_cnt), 0);
        checkOutput("rst2_wt",    32'(wt), 0);
        for (int i = 1; i <= 32; i++) begin
            int exp_addr;
            nextCycle();
            if (i == 2) applyStimulus(1, 1, 5'd5, 32'ha5a5_a5a5, 0, 0, 0, 0, 0, 0);
            if (i == 3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            exp_addr = (i < 3) ? i : ((i == 3) ? 5 : i - 1);
            checkOutput("wbi_wt",   32'(wt), 1);
            checkOutput("wbi_addr", 32'(reg_wt_addr), exp_addr);
            checkOutput("wbi_data", Data_in, (i == 3) ? 32'ha5a5_a5a5 : 32'h0);
            checkOutput("wbi_busy", 32'(init_busy), 32'(i < 32));
        end

        // Round-robin between INT and DBG.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 1, 5'd26, 32'h1234_ffff, 1, 5'd27, 32'hdead_beef);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rr_int_ready", 32'(int_ready), 32'(k % 2 == 0));
            checkOutput("rr_dbg_ready", 32'(dbg_ready), 32'(k % 2 == 1));
            if (k > 0) checkOutput("rr_addr", 32'(reg_wt_addr), (k % 2 == 1) ? 26 : 27);
            nextCycle();
            if (k == 5) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        checkOutput("rr_last_addr", 32'(reg_wt_addr), 27);
        checkOutput("rr_last_data", Data_in, 32'hdead_beef);
        checkOutput("rr_stall",     32'(stall_cnt), 6);

        // WB blocks a waiting interrupt for three cycles.
        nextCycle();
        applyStimulus(1, 1, 5'd12, 32'h1111_2222, 1, 5'd9, 32'h0bad_f00d, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("wbp_int_ready", 32'(int_ready), 0);
            nextCycle();
            if (k == 2) applyStimulus(1, 0, 0, 0, 1, 5'd9, 32'h0bad_f00d, 0, 0, 0);
        end
        @(negedge clk);
        checkOutput("wbp_grant",   32'(int_ready), 1);
        checkOutput("wbp_wb_addr", 32'(reg_wt_addr), 12);
        checkOutput("wbp_wb_data", Data_in, 32'h1111_2222);
        checkOutput("wbp_stall",   32'(stall_cnt), 9);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wbp_int_wt",   32'(wt), 1);
        checkOutput("wbp_int_addr", 32'(reg_wt_addr), 9);
        checkOutput("wbp_int_data", Data_in, 32'h0bad_f00d);

        // Debug write to $0 is acked but suppressed; the next one lands.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'haaaa_aaaa);
        @(negedge clk);
        checkOutput("z_dbg_ready", 32'(dbg_ready), 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h0000_0066);
        @(negedge clk);
        checkOutput("z_wt",         32'(wt), 0);
        checkOutput("z_dbg_ready2", 32'(dbg_ready), 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("z6_wt",   32'(wt), 1);
        checkOutput("z6_addr", 32'(reg_wt_addr), 6);
        checkOutput("z6_data", Data_in, 32'h0000_0066);

        // WB to $0 still blocks the interrupt for that cycle.
        nextCycle();
        applyStimulus(1, 1, 5'd0, 32'h5555_5555, 1, 5'd3, 32'h3333_3333, 0, 0, 0);
        @(negedge clk);
        checkOutput("wz_int_ready", 32'(int_ready), 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 1, 5'd3, 32'h3333_3333, 0, 0, 0);
        @(negedge clk);
        checkOutput("wz_wt",        32'(wt), 0);
        checkOutput("wz_int_ready", 32'(int_ready), 1);
        checkOutput("wz_stall",     32'(stall_cnt), 10);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wz_int_addr", 32'(reg_wt_addr), 3);

        // Reset in the middle of the clear sequence.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd8, 32'h0000_0088);
        for (int i = 1; i <= 9; i++) begin
            nextCycle();
            if (i == 9) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("mr_addr", 32'(reg_wt_addr), i);
        end
        checkOutput("mr_stall_pre", 32'(stall_cnt), 9);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("mr_wt",    32'(wt), 0);
        checkOutput("mr_stall", 32'(stall_cnt), 0);
        checkOutput("mr_busy",  32'(init_busy), 1);
        nextCycle();
        @(negedge clk);
        checkOutput("mr_restart_wt",   32'(wt), 1);
        checkOutput("mr_restart_addr", 32'(reg_wt_addr), 1);

        repeat (3) nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
